// File: rtl/debug_command_unit.sv
// debug_command_unit: MIPS-side endpoint of the MicroBlaze debug link.
// Decodes 32-bit control frames {code[31:26], valid[25], addr_type[24:16], address[15:0]}
// and drives the pipeline core (run/step enable, soft reset, instruction loading,
// debug data requests). Status and requested data go back on o_frame_to_blaze.
// Ports:
//   i_clock, i_reset (sync, active-low)
//   i_frame_from_blaze / o_frame_to_blaze, o_reply_valid : MicroBlaze link
//   o_pipe_enable, o_pipe_reset, i_halt                   : core control
//   o_instr_we, o_instr_addr, o_instr_data                : instruction-memory load
//   o_req_valid, o_req_type, o_req_addr, i_req_data, i_req_ready : debug reads
module debug_command_unit #(
  parameter int unsigned NB_CONTROL_FRAME = 32,
  parameter int unsigned NB_INSTR         = 32,
  parameter int unsigned NB_INSTR_ADDR    = 9,
  parameter int unsigned N_ADDR           = 512,
  parameter int unsigned REQ_TIMEOUT      = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  output logic                        o_reply_valid,
  output logic                        o_pipe_enable,
  output logic                        o_pipe_reset,
  input  logic                        i_halt,
  output logic                        o_instr_we,
  output logic [NB_INSTR_ADDR-1:0]    o_instr_addr,
  output logic [NB_INSTR-1:0]         o_instr_data,
  output logic                        o_req_valid,
  output logic [8:0]                  o_req_type,
  output logic [15:0]                 o_req_addr,
  input  logic [NB_CONTROL_FRAME-1:0] i_req_data,
  input  logic                        i_req_ready
);

  localparam int unsigned NB_CODE  = 6;
  localparam int unsigned NB_TYPE  = 9;
  localparam int unsigned NB_ADDR  = 16;
  localparam int unsigned NB_PAD   = NB_CONTROL_FRAME - NB_CODE - 1;
  localparam int unsigned NB_TIMER = $clog2(REQ_TIMEOUT + 1);

  localparam logic [NB_CODE-1:0] CMD_START     = 6'b000001;
  localparam logic [NB_CODE-1:0] CMD_RESET     = 6'b000010;
  localparam logic [NB_CODE-1:0] CMD_REQ_DATA  = 6'b000011;
  localparam logic [NB_CODE-1:0] CMD_LOAD_LSB  = 6'b000100;
  localparam logic [NB_CODE-1:0] CMD_LOAD_MSB  = 6'b000101;
  localparam logic [NB_CODE-1:0] CMD_MODE_GET  = 6'b001000;
  localparam logic [NB_CODE-1:0] CMD_MODE_CONT = 6'b001001;
  localparam logic [NB_CODE-1:0] CMD_MODE_STEP = 6'b001010;
  localparam logic [NB_CODE-1:0] CMD_STEP      = 6'b100000;

  typedef enum logic [1:0] {IDLE, RUN, REQ_WAIT} state_t;

  state_t                  state;
  state_t                  ret_state;
  logic                    mode_cont;
  logic                    halted;
  logic                    valid_q;
  logic [NB_INSTR_ADDR-1:0] load_ptr;
  logic [NB_ADDR-1:0]      lsb_hold;
  logic [NB_TIMER-1:0]     timer;

  // Frame field views
  logic [NB_CODE-1:0]          frame_code;
  logic                        frame_valid;
  logic [NB_TYPE-1:0]          frame_type;
  logic [NB_ADDR-1:0]          frame_addr;
  logic                        accept;
  logic [NB_CONTROL_FRAME-1:0] ack_frame;
  logic [NB_CONTROL_FRAME-1:0] nack_frame;
  logic [NB_CONTROL_FRAME-1:0] mode_frame;

  assign frame_code  = i_frame_from_blaze[NB_CONTROL_FRAME-1 -: NB_CODE];
  assign frame_valid = i_frame_from_blaze[NB_PAD];
  assign frame_type  = i_frame_from_blaze[NB_TYPE+NB_ADDR-1:NB_ADDR];
  assign frame_addr  = i_frame_from_blaze[NB_ADDR-1:0];
  assign accept      = frame_valid & ~valid_q;
  assign ack_frame   = {frame_code, 1'b1, {NB_PAD{1'b0}}};
  assign nack_frame  = {frame_code, 1'b0, {NB_PAD{1'b0}}};
  assign mode_frame  = {{(NB_CONTROL_FRAME-3){1'b0}}, halted, (state == RUN), mode_cont};

  // Control FSM, command decode and all registered outputs
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state            <= IDLE;
      ret_state        <= IDLE;
      mode_cont        <= 1'b0;
      halted           <= 1'b0;
      valid_q          <= 1'b0;
      load_ptr         <= '0;
      lsb_hold         <= '0;
      timer            <= '0;
      o_frame_to_blaze <= '0;
      o_reply_valid    <= 1'b0;
      o_pipe_enable    <= 1'b0;
      o_pipe_reset     <= 1'b0;
      o_instr_we       <= 1'b0;
      o_instr_addr     <= '0;
      o_instr_data     <= '0;
      o_req_valid      <= 1'b0;
      o_req_type       <= '0;
      o_req_addr       <= '0;
    end else begin
      valid_q       <= frame_valid;
      o_reply_valid <= 1'b0;
      o_pipe_reset  <= 1'b0;
      o_instr_we    <= 1'b0;
      o_pipe_enable <= 1'b0;

      // Autonomous behaviour per state; a command accepted below overrides it
      case (state)
        IDLE: ;
        RUN: begin
          if (i_halt) halted <= 1'b1;
          if (mode_cont) begin
            if (i_halt) state <= IDLE;
            else        o_pipe_enable <= 1'b1;
          end
        end
        REQ_WAIT: begin
          if (i_req_ready || timer == NB_TIMER'(REQ_TIMEOUT - 1)) begin
            o_frame_to_blaze <= i_req_ready ? i_req_data : NB_CONTROL_FRAME'(32'hDEAD_BEEF);
            o_reply_valid    <= 1'b1;
            o_req_valid      <= 1'b0;
            state            <= ret_state;
            o_pipe_enable    <= (ret_state == RUN) & mode_cont & ~i_halt;
          end else begin
            timer <= timer + NB_TIMER'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Commands on a valid rising edge; edges during REQ_WAIT are dropped
      if (accept && state != REQ_WAIT) begin
        o_reply_valid <= 1'b1;
        case (frame_code)
          CMD_START: begin
            state            <= RUN;
            halted           <= 1'b0;
            o_pipe_enable    <= mode_cont & ~i_halt;
            o_frame_to_blaze <= ack_frame;
          end
          CMD_RESET: begin
            state            <= IDLE;
            halted           <= 1'b0;
            load_ptr         <= '0;
            o_pipe_reset     <= 1'b1;
            o_pipe_enable    <= 1'b0;
            o_frame_to_blaze <= ack_frame;
          end
          CMD_MODE_CONT: begin
            mode_cont        <= 1'b1;
            if (state == RUN) o_pipe_enable <= ~i_halt;
            o_frame_to_blaze <= ack_frame;
          end
          CMD_MODE_STEP: begin
            mode_cont        <= 1'b0;
            o_pipe_enable    <= 1'b0;
            o_frame_to_blaze <= ack_frame;
          end
          CMD_MODE_GET: o_frame_to_blaze <= mode_frame;
          CMD_STEP: begin
            // Halt takes priority over a step request
            if (state == RUN && !mode_cont && !i_halt) begin
              o_pipe_enable    <= 1'b1;
              o_frame_to_blaze <= ack_frame;
            end else begin
              o_frame_to_blaze <= nack_frame;
            end
          end
          CMD_LOAD_LSB: begin
            if (state == RUN) begin
              o_frame_to_blaze <= nack_frame;
            end else begin
              lsb_hold         <= frame_addr;
              o_frame_to_blaze <= ack_frame;
            end
          end
          CMD_LOAD_MSB: begin
            if (state == RUN) begin
              o_frame_to_blaze <= nack_frame;
            end else begin
              o_instr_we       <= 1'b1;
              o_instr_addr     <= load_ptr;
              o_instr_data     <= NB_INSTR'({frame_addr, lsb_hold});
              load_ptr         <= (load_ptr == NB_INSTR_ADDR'(N_ADDR - 1)) ? '0
                                  : load_ptr + NB_INSTR_ADDR'(1);
              o_frame_to_blaze <= ack_frame;
            end
          end
          CMD_REQ_DATA: begin
            // Reply is sent when the read completes or times out
            o_reply_valid <= 1'b0;
            o_req_valid   <= 1'b1;
            o_req_type    <= frame_type;
            o_req_addr    <= frame_addr;
            o_pipe_enable <= 1'b0;
            ret_state     <= state;
            state         <= REQ_WAIT;
            timer         <= '0;
          end
          default: o_frame_to_blaze <= nack_frame;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_command_unit.sv
// Testbench for debug_command_unit: directed scenarios followed by randomized
// command traffic, checked against a transaction-level model through reply and
// instruction-write scoreboards.
module tb_debug_command_unit;

  logic        i_clock;
  logic        i_reset;
  logic [31:0] i_frame_from_blaze;
  logic [31:0] o_frame_to_blaze;
  logic        o_reply_valid;
  logic        o_pipe_enable;
  logic        o_pipe_reset;
  logic        i_halt;
  logic        o_instr_we;
  logic [8:0]  o_instr_addr;
  logic [31:0] o_instr_data;
  logic        o_req_valid;
  logic [8:0]  o_req_type;
  logic [15:0] o_req_addr;
  logic [31:0] i_req_data;
  logic        i_req_ready;

  debug_command_unit dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_frame_from_blaze (i_frame_from_blaze),
    .o_frame_to_blaze   (o_frame_to_blaze),
    .o_reply_valid      (o_reply_valid),
    .o_pipe_enable      (o_pipe_enable),
    .o_pipe_reset       (o_pipe_reset),
    .i_halt             (i_halt),
    .o_instr_we         (o_instr_we),
    .o_instr_addr       (o_instr_addr),
    .o_instr_data       (o_instr_data),
    .o_req_valid        (o_req_valid),
    .o_req_type         (o_req_type),
    .o_req_addr         (o_req_addr),
    .i_req_data         (i_req_data),
    .i_req_ready        (i_req_ready)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  localparam logic [5:0] C_START = 6'h01, C_RESET = 6'h02, C_REQ = 6'h03,
                         C_LSB = 6'h04, C_MSB = 6'h05, C_GET = 6'h08,
                         C_CONT = 6'h09, C_STEPM = 6'h0A, C_STEP = 6'h20;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;
  int prst_cnt = 0;
  int exp_prst = 0;

  logic [31:0] exp_reply[$];
  logic [40:0] exp_wr[$];

  // Reference model (transaction level)
  bit          m_run, m_cont, m_halted;
  int          m_ptr;
  logic [15:0] m_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: pops scoreboards whenever the DUT presents a reply or a write
  always @(negedge i_clock) begin
    if (o_pipe_enable) en_cnt++;
    if (o_pipe_reset)  prst_cnt++;
    if (o_reply_valid) begin
      if (exp_reply.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_reply: got %h required no reply", o_frame_to_blaze);
      end else begin
        chk("reply", 64'(o_frame_to_blaze), 64'(exp_reply.pop_front()));
      end
    end
    if (o_instr_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %h data %h required no write", o_instr_addr, o_instr_data);
      end else begin
        chk("instr_write", 64'({o_instr_addr, o_instr_data}), 64'(exp_wr.pop_front()));
      end
    end
  end

  task automatic tick;
    @(negedge i_clock);
    #1;
  endtask

  task automatic model_reset;
    m_run = 0; m_cont = 0; m_halted = 0; m_ptr = 0; m_hold = '0;
  endtask

  // A core halt while running sets halted; in CONT mode it also stops the run
  task automatic apply_halt;
    if (i_halt && m_run) begin
      m_halted = 1;
      if (m_cont) m_run = 0;
    end
  endtask

  task automatic model_cmd(input logic [5:0] c, input logic [15:0] a, output logic [31:0] rep);
    logic [31:0] ack, nack;
    ack  = {c, 1'b1, 25'b0};
    nack = {c, 1'b0, 25'b0};
    rep  = nack;
    case (c)
      C_START: begin m_run = 1; m_halted = 0; rep = ack; end
      C_RESET: begin m_run = 0; m_halted = 0; m_ptr = 0; exp_prst++; rep = ack; end
      C_CONT:  begin m_cont = 1; rep = ack; end
      C_STEPM: begin m_cont = 0; rep = ack; end
      C_GET:   rep = {29'b0, m_halted, m_run, m_cont};
      C_STEP:  if (m_run && !m_cont && !i_halt) rep = ack;
      C_LSB:   if (!m_run) begin m_hold = a; rep = ack; end
      C_MSB:   if (!m_run) begin
                 exp_wr.push_back({9'(m_ptr), a, m_hold});
                 m_ptr = (m_ptr + 1) % 512;
                 rep = ack;
               end
      default: rep = nack;
    endcase
    apply_halt();
  endtask

  task automatic send_cmd(input logic [5:0] c, input logic [15:0] a, input int hold);
    logic [31:0] rep;
    model_cmd(c, a, rep);
    exp_reply.push_back(rep);
    i_frame_from_blaze = {c, 1'b1, 9'($urandom), a};
    repeat (hold) tick();
    i_frame_from_blaze[25] = 1'b0;
    tick();
    tick();
    chk("reply_drain", 64'(exp_reply.size()), 64'd0);
  endtask

  // Debug read: ready after d cycles of o_req_valid (d=0: never)
  task automatic do_req(input logic [8:0] t, input logic [15:0] a, input int d,
                        input logic [31:0] data, input bit inject_start);
    int cnt;
    exp_reply.push_back((d >= 1 && d <= 16) ? data : 32'hDEAD_BEEF);
    i_frame_from_blaze = {C_REQ, 1'b1, t, a};
    tick();
    i_frame_from_blaze[25] = 1'b0;
    chk("req_valid_rise", 64'(o_req_valid), 64'd1);
    chk("req_fields", 64'({o_req_type, o_req_addr}), 64'({t, a}));
    chk("req_enable_frozen", 64'(o_pipe_enable), 64'd0);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (o_req_valid) cnt++;
      i_req_ready = (k == d);
      i_req_data  = (k == d) ? data : 32'($urandom);
      if (inject_start && k == 4) i_frame_from_blaze = {C_START, 1'b1, 25'b0};
      if (inject_start && k == 5) i_frame_from_blaze[25] = 1'b0;
      tick();
    end
    i_req_ready = 1'b0;
    chk("req_valid_cycles", 64'(cnt), 64'((d >= 1 && d <= 16) ? d : 16));
    tick();
    chk("req_reply_drain", 64'(exp_reply.size()), 64'd0);
  endtask

  task automatic set_halt(input logic v);
    i_halt = v;
    tick();
    tick();
    apply_halt();
  endtask

  task automatic hw_reset;
    i_reset = 1'b0;
    i_frame_from_blaze = '0;
    i_halt = 1'b0;
    i_req_ready = 1'b0;
    i_req_data = '0;
    tick(); tick();
    chk("rst_frame", 64'(o_frame_to_blaze), 64'd0);
    chk("rst_ctrl", 64'({o_reply_valid, o_pipe_enable, o_pipe_reset, o_instr_we, o_req_valid}), 64'd0);
    chk("rst_buses", 64'({o_instr_addr, o_instr_data, o_req_type, o_req_addr}), 64'd0);
    i_reset = 1'b1;
    model_reset();
    tick();
  endtask

  initial begin
    int en0, p0, sel;
    logic [5:0]  c;
    logic [15:0] a;
    i_reset = 1'b0;
    i_frame_from_blaze = '0;
    i_halt = 1'b0;
    i_req_ready = 1'b0;
    i_req_data = '0;
    model_reset();
    hw_reset();

    // Continuous run, then halt
    send_cmd(C_CONT, 16'h0, 1);
    send_cmd(C_START, 16'h0, 1);
    chk("cont_enable", 64'(o_pipe_enable), 64'd1);
    send_cmd(C_GET, 16'h0, 1);
    i_halt = 1'b1;
    tick();
    chk("halt_enable_drop", 64'(o_pipe_enable), 64'd0);
    tick();
    apply_halt();
    send_cmd(C_GET, 16'h0, 1);
    set_halt(1'b0);

    // Instruction loads, including pointer wrap
    send_cmd(C_LSB, 16'h00F0, 1);
    send_cmd(C_MSB, 16'h0FFF, 1);
    send_cmd(C_LSB, 16'h1234, 1);
    send_cmd(C_MSB, 16'hABCD, 1);
    for (int i = 0; i < 509; i++) send_cmd(C_MSB, 16'(i), 1);
    chk("ptr_model", 64'(m_ptr), 64'd511);
    send_cmd(C_MSB, 16'hBEEF, 1);
    send_cmd(C_MSB, 16'hCAFE, 1);

    // Step mode
    send_cmd(C_STEPM, 16'h0, 1);
    send_cmd(C_START, 16'h0, 1);
    en0 = en_cnt;
    repeat (3) send_cmd(C_STEP, 16'h0, 1);
    chk("three_steps", 64'(en_cnt - en0), 64'd3);
    en0 = en_cnt;
    send_cmd(C_STEP, 16'h0, 5);
    chk("held_valid_one_step", 64'(en_cnt - en0), 64'd1);
    send_cmd(C_RESET, 16'h0, 1);
    send_cmd(C_STEP, 16'h0, 1);

    // Debug reads from IDLE
    do_req(9'b0_0000_0010, 16'h0001, 3, 32'h1234_5678, 1'b0);
    do_req(9'h1A5, 16'h00C3, 0, 32'h0, 1'b1);
    send_cmd(C_GET, 16'h0, 1);

    // Soft reset from a continuous run
    send_cmd(C_CONT, 16'h0, 1);
    send_cmd(C_START, 16'h0, 1);
    chk("run_before_reset", 64'(o_pipe_enable), 64'd1);
    p0 = prst_cnt;
    send_cmd(C_RESET, 16'h0, 1);
    chk("pipe_reset_pulse", 64'(prst_cnt - p0), 64'd1);
    chk("reset_enable_off", 64'(o_pipe_enable), 64'd0);
    send_cmd(C_GET, 16'h0, 1);
    send_cmd(C_MSB, 16'h5555, 1);

    // Hardware reset in the middle of a request
    i_frame_from_blaze = {C_REQ, 1'b1, 9'h3, 16'h7};
    tick();
    chk("req_pending", 64'(o_req_valid), 64'd1);
    i_reset = 1'b0;
    i_frame_from_blaze = '0;
    tick();
    chk("hw_reset_drops_req", 64'({o_req_valid, o_reply_valid, o_pipe_enable, o_frame_to_blaze}), 64'd0);
    hw_reset();

    // Nacks while running and for an unknown code
    send_cmd(C_CONT, 16'h0, 1);
    send_cmd(C_START, 16'h0, 1);
    send_cmd(C_MSB, 16'h0001, 1);
    send_cmd(6'h3F, 16'h0, 1);
    send_cmd(C_RESET, 16'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 5) == 0) set_halt(~i_halt);
      sel = int'($urandom_range(0, 11));
      a = 16'($urandom);
      case (sel)
        0: c = C_START;   1: c = C_RESET;  2: c = C_CONT;  3: c = C_STEPM;
        4: c = C_GET;     5: c = C_STEP;   6: c = C_LSB;   7: c = C_MSB;
        9: begin
             do c = 6'($urandom);
             while (c inside {C_START, C_RESET, C_REQ, C_LSB, C_MSB, C_GET, C_CONT, C_STEPM, C_STEP});
           end
        10: c = C_STEP;
        11: c = C_MSB;
        default: c = C_REQ;
      endcase
      if (c == C_REQ) do_req(9'($urandom), a, int'($urandom_range(0, 18)), 32'($urandom), 1'b0);
      else send_cmd(c, a, int'($urandom_range(1, 3)));
      chk("enable_level", 64'(o_pipe_enable), 64'(m_run && m_cont && !i_halt));
    end

    tick(); tick();
    chk("reply_queue_empty", 64'(exp_reply.size()), 64'd0);
    chk("write_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("pipe_reset_total", 64'(prst_cnt), 64'(exp_prst));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_command_unit.md
Name: debug_command_unit

Overview:
- MIPS-side endpoint of the MicroBlaze link; sits between `i_frame_from_blaze` and the pipeline core.
- Decodes 32-bit control frames and drives the core: run/step enable, soft reset, instruction-memory loading, debug data requests.
- Returns status and requested data to MicroBlaze on `o_frame_to_blaze`.
- Frame fields: `[31:26]` code, `[25]` valid, `[24:16]` addr_type, `[15:0]` address.

Parameters:
- NB_CONTROL_FRAME, 32, frame width.
- NB_INSTR, 32, instruction word width.
- NB_INSTR_ADDR, 9, instruction-memory address width.
- N_ADDR, 512, instruction-memory depth; load pointer wraps here.
- REQ_TIMEOUT, 16, maximum cycles to wait for `i_req_ready`.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_frame_from_blaze  in  32  command frame.
- o_frame_to_blaze  out  32  reply frame.
- o_reply_valid  out  1  one-cycle pulse when `o_frame_to_blaze` is updated.
- o_pipe_enable  out  1  pipeline advance enable.
- o_pipe_reset  out  1  one-cycle soft reset pulse to the core.
- i_halt  in  1  core has fetched the end-of-program instruction.
- o_instr_we  out  1  instruction-memory write strobe.
- o_instr_addr  out  9  instruction-memory write address.
- o_instr_data  out  32  instruction-memory write data.
- o_req_valid  out  1  debug read request to latches, regfile or memories.
- o_req_type  out  9  addr_type of the request.
- o_req_addr  out  16  address of the request.
- i_req_data  in  32  read data.
- i_req_ready  in  1  `i_req_data` is valid this cycle.

Behaviour:
- Reset (`i_reset`=0 at a clock edge): all outputs 0, state IDLE, mode=STEP, load pointer 0, LSB holding register 0, previous-valid flag 0.
- Command acceptance:
  - A command is accepted only on a rising edge of frame bit 25 (valid=1 this cycle, 0 last cycle).
  - Holding valid high does not re-trigger.
  - Edges arriving in REQ_WAIT are dropped; no reply is sent.
- Actions take effect the cycle after acceptance. `o_reply_valid` pulses in that same cycle, except for REQ_DATA.
- States:
  - IDLE → RUN on START.
  - RUN → IDLE on RESET, or on `i_halt` in CONT mode.
  - IDLE/RUN → REQ_WAIT on REQ_DATA.
  - REQ_WAIT → the previous state on `i_req_ready` or on timeout.
- START (code 000001): enter RUN. Ack frame = {code, 1, 25'b0}.
- RESET (000010):
  - `o_pipe_reset` high exactly one cycle; `o_pipe_enable`=0; state IDLE; load pointer 0.
  - Mode is retained. Ack.
- MODE_SET_CONT (001001) / MODE_SET_STEP (001010): set mode. Ack.
  - Switching CONT→STEP while in RUN deasserts `o_pipe_enable` the next cycle.
- MODE_GET (001000): reply {26'b0, 3'b0, halted, running, mode}, where mode 1=CONT.
- STEP (100000): in RUN and STEP mode with `i_halt`=0, `o_pipe_enable` high exactly one cycle, then ack. Otherwise nack.
- `o_pipe_enable` in RUN and CONT mode: held 1 while `i_halt`=0. Deasserts the cycle after `i_halt` is seen, then state IDLE.
- LOAD_INSTR_LSB (000100): holding register ← address. Ack.
- LOAD_INSTR_MSB (000101):
  - Next cycle: `o_instr_we`=1 for one cycle, `o_instr_data`={address, holding}, `o_instr_addr`=pointer.
  - Pointer then increments; N_ADDR-1 wraps to 0.
  - MSB without a prior LSB uses the current holding value (0 after reset).
  - Ack.
- Loads while in RUN: ignored, nack.
- REQ_DATA (000011):
  - `o_req_valid`=1 with `o_req_type`/`o_req_addr` latched from the frame. Held until `i_req_ready`.
  - In the `i_req_ready` cycle: `o_req_valid` drops next cycle; reply = `i_req_data`; `o_reply_valid` pulses.
  - If REQ_TIMEOUT cycles elapse without ready: reply 32'hDEAD_BEEF, return to previous state.
  - Pipeline enable is frozen at 0 during REQ_WAIT and restored on exit.
- Unknown code: nack {code, 0, 25'b0}.
- `o_frame_to_blaze` holds its last value between replies.
- Simultaneous `i_halt` and STEP command: halt wins, nack.
- Hardware reset mid-request drops the request immediately.

Test Plan:
- Reset, then MODE_SET_CONT edge, then START edge → `o_reply_valid` pulses with 0x0600_0000-style acks (START ack 0x0600_0000); `o_pipe_enable`=1 from the cycle after START. Assert `i_halt` → enable 0 next cycle; MODE_GET returns 0x0000_0003→0x0000_0005 (halted, not running, CONT).
- LSB address=0x00F0, then MSB address=0x0FFF → one `o_instr_we` pulse with data 0x0FFF_00F0, addr 0. A second pair writes addr 1. Preload the pointer to 511 via 511 loads → the next write goes to 511, the following to 0.
- STEP mode: START, then three STEP edges → exactly three single-cycle enable pulses. Valid held high 5 cycles → still one pulse. STEP in IDLE → nack 0x8000_0000.
- REQ_DATA type 9'b000_0000_10, addr 1; `i_req_ready` after 3 cycles with 0x1234_5678 → `o_req_valid` high 3 cycles, reply 0x1234_5678. Ready never asserted → reply 0xDEAD_BEEF after 16 cycles. START edge during the wait is dropped.
- RUN in CONT, RESET edge → `o_pipe_reset` one-cycle pulse, enable 0, pointer 0, MODE_GET still shows CONT. `i_reset`=0 during REQ_WAIT → all outputs 0 next edge.
- LOAD_INSTR_MSB while running → no write, nack 0x1400_0000. Code 0x3F → nack 0xFC00_0000.
